// File: rtl/trace_pkg.sv
// trace_pkg
//   Shared constants and the trace-entry record for the register-write tracer.
//   Optional build macro: TRACE_PC_EN. When it is defined, each entry also
//   carries the captured PC. When it is undefined, the PC field is absent
//   from the record.
//   No ports (package).
package trace_pkg;

  localparam int SEQ_W      = 16;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
`ifdef TRACE_PC_EN
    logic [DATA_W-1:0]     pc;
`endif
  } trace_entry_t;

endpackage

// File: rtl/reg_write_tracer_if.sv
// reg_write_tracer_if
//   Bundles the CPU write-capture inputs and the trace consumer signals.
//   Parameters : DEPTH (trace entries), DROP_W (dropped-counter width)
//   Capture    : wr_en, wr_addr, wr_data, pc
//   Consumer   : pop, clear_ovf
//   Head/status: out_valid, out_addr, out_data, out_pc, out_seq,
//                count, overflow, dropped
//   Modports   : slave  (tracer side), master (CPU/consumer side)
interface reg_write_tracer_if #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  import trace_pkg::*;

  logic                      wr_en;
  logic [REG_ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [DATA_W-1:0]         pc;
  logic                      pop;
  logic                      clear_ovf;

  logic                      out_valid;
  logic [REG_ADDR_W-1:0]     out_addr;
  logic [DATA_W-1:0]         out_data;
  logic [DATA_W-1:0]         out_pc;
  logic [SEQ_W-1:0]          out_seq;
  logic [$clog2(DEPTH):0]    count;
  logic                      overflow;
  logic [DROP_W-1:0]         dropped;

  modport slave (
    input  wr_en, wr_addr, wr_data, pc, pop, clear_ovf,
    output out_valid, out_addr, out_data, out_pc, out_seq,
           count, overflow, dropped
  );

  modport master (
    output wr_en, wr_addr, wr_data, pc, pop, clear_ovf,
    input  out_valid, out_addr, out_data, out_pc, out_seq,
           count, overflow, dropped
  );

endinterface

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem
//   DEPTH-entry storage array for trace entries: synchronous write port,
//   combinational read port. Contents are not reset.
//   Ports: clk   - clock
//          we    - write enable
//          waddr - write index
//          wdata - entry to store
//          raddr - read index
//          rdata - entry at raddr (combinational)
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reg_write_tracer.sv
// reg_write_tracer
//   Records CPU register-file writes (excluding $0) into a first-word-fall-
//   through trace FIFO. Each entry holds a 16-bit sequence number, register
//   number, write data and (optionally) the PC. When the FIFO is full and
//   no pop occurs, new events are dropped; a sticky overflow flag and a
//   saturating dropped counter record the loss.
//   Optional build macro: TRACE_PC_EN (store PC per entry and drive out_pc;
//   otherwise out_pc is tied to 0).
//   Ports: clk   - clock, rising edge
//          reset - asynchronous, active-high
//          bus   - reg_write_tracer_if.slave (capture, consumer, status)
module reg_write_tracer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  reg_write_tracer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic [SEQ_W-1:0]  seq;
  logic              overflow;
  logic [DROP_W-1:0] dropped;

  logic              push_req;
  logic              do_push;
  logic              do_pop;
  logic              drop;
  logic              empty;
  logic              full;

  trace_entry_t      wr_entry;
  trace_entry_t      head;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign push_req = bus.wr_en && (bus.wr_addr != '0);
  assign do_pop   = bus.pop && !empty;
  // A pop frees the slot on the same edge, so a push into a full FIFO
  // alongside a pop is stored rather than dropped.
  assign do_push  = push_req && (!full || do_pop);
  assign drop     = push_req && full && !do_pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.seq  = seq;
    wr_entry.addr = bus.wr_addr;
    wr_entry.data = bus.wr_data;
`ifdef TRACE_PC_EN
    wr_entry.pc   = bus.pc;
`endif
  end

`ifndef TRACE_PC_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

  trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
        seq  <= seq + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as clear_ovf restarts the tally at one.
      if (drop) begin
        overflow <= 1'b1;
        dropped  <= bus.clear_ovf ? DROP_W'(1) : sat_inc(dropped);
      end else if (bus.clear_ovf) begin
        overflow <= 1'b0;
        dropped  <= '0;
      end
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_addr  = empty ? '0 : head.addr;
  assign bus.out_data  = empty ? '0 : head.data;
  assign bus.out_seq   = empty ? '0 : head.seq;
`ifdef TRACE_PC_EN
  assign bus.out_pc    = empty ? '0 : head.pc;
`else
  assign bus.out_pc    = '0;
`endif
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.dropped   = dropped;

endmodule

// File: tb/tb_reg_write_tracer.sv
module tb_reg_write_tracer;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_write_tracer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  reg_write_tracer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] seq;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_seq;
  logic        m_ovf;
  int          m_drop;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq  = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Reference behaviour for one rising edge, from the tracer's rules.
  task automatic model_edge();
    bit   push_req;
    bit   popped;
    bit   lost;
    ent_t e;
    if (reset) begin
      model_reset();
    end else begin
      push_req = bus.wr_en && (bus.wr_addr != 5'd0);
      popped   = bus.pop && (q.size() > 0);
      lost     = push_req && (q.size() == DEPTH) && !popped;
      if (popped) void'(q.pop_front());
      if (push_req && !lost) begin
        e.seq  = m_seq;
        e.addr = bus.wr_addr;
        e.data = bus.wr_data;
        e.pc   = bus.pc;
        q.push_back(e);
        m_seq  = m_seq + 16'd1;
      end
      if (bus.clear_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (lost) begin
        m_ovf = 1'b1;
        if (m_drop < (1 << DROP_W) - 1) m_drop++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit we, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input bit po, input bit cl);
    bus.wr_en     = we;
    bus.wr_addr   = a;
    bus.wr_data   = d;
    bus.pc        = p;
    bus.pop       = po;
    bus.clear_ovf = cl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all(input string tag);
    ent_t        h;
    logic [31:0] epc;
    if (q.size() > 0) h = q[0];
    else h = '{default: '0};
`ifdef TRACE_PC_EN
    epc = h.pc;
`else
    epc = 32'd0;
`endif
    chk({tag, ".valid"},    bus.out_valid, 64'(q.size() != 0));
    chk({tag, ".count"},    bus.count,     64'(q.size()));
    chk({tag, ".addr"},     bus.out_addr,  64'(h.addr));
    chk({tag, ".data"},     bus.out_data,  64'(h.data));
    chk({tag, ".pc"},       bus.out_pc,    64'(epc));
    chk({tag, ".seq"},      bus.out_seq,   64'(h.seq));
    chk({tag, ".overflow"}, bus.overflow,  64'(m_ovf));
    chk({tag, ".dropped"},  bus.dropped,   64'(m_drop));
  endtask

  task automatic push_rand();
    drive(1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom, 1'b0, 1'b0);
    tick();
  endtask

  task automatic sync_reset_cycle();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    chk("reset.count_zero", bus.count, 64'd0);
    reset = 1'b0;

    // Basic push
    drive(1'b1, 5'd8, 32'hDEADBEEF, 32'h40, 1'b0, 1'b0);
    tick();
    idle();
    check_all("basic");
    chk("basic.valid_c", bus.out_valid, 64'd1);
    chk("basic.addr_c",  bus.out_addr,  64'd8);
    chk("basic.data_c",  bus.out_data,  64'hDEADBEEF);
`ifdef TRACE_PC_EN
    chk("basic.pc_c",    bus.out_pc,    64'h40);
`else
    chk("basic.pc_c",    bus.out_pc,    64'h0);
`endif
    chk("basic.seq_c",   bus.out_seq,   64'd0);
    chk("basic.count_c", bus.count,     64'd1);

    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check_all("pop_basic");
    tick();
    check_all("pop_empty");

    // Push and pop together while empty: only the push happens
    drive(1'b1, 5'd3, 32'h1234_5678, 32'h44, 1'b1, 1'b0);
    tick();
    idle();
    check_all("pushpop_empty");
    chk("pushpop_empty.seq_c", bus.out_seq, 64'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();

    // Writes to $0 are filtered
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd0, $urandom, $urandom, 1'b0, 1'b0);
      tick();
    end
    idle();
    check_all("filter");
    chk("filter.valid_c", bus.out_valid, 64'd0);
    drive(1'b1, 5'd5, 32'hCAFE_F00D, 32'h48, 1'b0, 1'b0);
    tick();
    idle();
    chk("filter.seq_after", bus.out_seq, 64'd2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();

    // Full FIFO with simultaneous push and pop
    sync_reset_cycle();
    for (int i = 0; i < DEPTH; i++) push_rand();
    idle();
    check_all("fill8");
    drive(1'b1, 5'd9, 32'hA5A5_0009, 32'h90, 1'b1, 1'b0);
    tick();
    idle();
    check_all("full_pushpop");
    chk("full_pushpop.count_c", bus.count, 64'd8);
    chk("full_pushpop.ovf_c",   bus.overflow, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_pushpop.drain_seq", bus.out_seq, 64'(i + 1));
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      tick();
    end
    idle();
    check_all("full_pushpop_drained");

    // Overflow: 10 pushes into an 8-deep FIFO
    sync_reset_cycle();
    for (int i = 0; i < 10; i++) push_rand();
    idle();
    check_all("overflow");
    chk("overflow.count_c",   bus.count,    64'd8);
    chk("overflow.ovf_c",     bus.overflow, 64'd1);
    chk("overflow.dropped_c", bus.dropped,  64'd2);
    for (int i = 0; i < DEPTH; i++) begin
      chk("overflow.drain_seq", bus.out_seq, 64'(i));
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      tick();
    end
    idle();
    check_all("overflow_drained");

    // Clear racing a drop: the drop wins
    for (int i = 0; i < DEPTH; i++) push_rand();
    drive(1'b1, 5'd7, 32'h7777_7777, 32'h70, 1'b0, 1'b1);
    tick();
    idle();
    check_all("clear_race");
    chk("clear_race.ovf_c",     bus.overflow, 64'd1);
    chk("clear_race.dropped_c", bus.dropped,  64'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    idle();
    check_all("clear_only");
    chk("clear_only.dropped_c", bus.dropped, 64'd0);

    // Dropped counter saturates
    for (int i = 0; i < 260; i++) push_rand();
    idle();
    check_all("saturate");
    chk("saturate.dropped_c", bus.dropped, 64'd255);

    // Asynchronous reset in the middle of operation
    sync_reset_cycle();
    for (int i = 0; i < 3; i++) push_rand();
    idle();
    chk("midreset.count_before", bus.count, 64'd3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("midreset_async");
    chk("midreset.valid_c", bus.out_valid, 64'd0);
    tick();
    reset = 1'b0;
    push_rand();
    idle();
    check_all("midreset_next");
    chk("midreset.seq_c", bus.out_seq, 64'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, $urandom,
            $urandom_range(0, 9) < 4,
            $urandom_range(0, 19) == 0);
      tick();
      check_all("random");
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_tracer.md
REG_WRITE_TRACER -- requirements
Module: reg_write_tracer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of trace entries; a power of two, at least 2.
REQ-002 SHALL have parameter DROP_W, default 8, width of the dropped-event counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, the CPU register-file write strobe (WriteReg).
REQ-006 SHALL have port wr_addr, input, 5, the destination register (WriteRegOut).
REQ-007 SHALL have port wr_data, input, 32, the register write data (WriteData).
REQ-008 SHALL have port pc, input, 32, the CPU PC register value.
REQ-009 SHALL have port pop, input, 1, consumer strobe to remove the head entry.
REQ-010 SHALL have port clear_ovf, input, 1, which clears the overflow flag and the dropped-event counter.
REQ-011 SHALL have port out_valid, output, 1, high when the head entry is presented.
REQ-012 SHALL have port out_addr, output, 5, the head entry's register number.
REQ-013 SHALL have port out_data, output, 32, the head entry's write data.
REQ-014 SHALL have port out_pc, output, 32, the head entry's captured PC.
REQ-015 SHALL have port out_seq, output, 16, the head entry's sequence number.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1, the current occupancy.
REQ-017 SHALL have port overflow, output, 1, a sticky flag set when an entry is lost.
REQ-018 SHALL have port dropped, output, DROP_W, the number of lost entries.

Function
REQ-019 SHALL accept an event when wr_en=1 and wr_addr!=0; writes to $0 are never recorded and never counted.
REQ-020 SHALL store an accepted event as {seq, wr_addr, wr_data, pc}, sampled on the same clk edge.
REQ-021 SHALL assign seq from a 16-bit counter that increments per accepted-and-stored event and wraps from 0xFFFF to 0.
REQ-022 SHALL behave as a first-word-fall-through FIFO: out_valid = (count != 0), and the head fields drive the outputs combinationally from storage.
REQ-023 SHALL make an event pushed into an empty FIFO visible on the outputs in the cycle after the push edge (latency 1).
REQ-024 SHALL remove the head on a clk edge where pop=1 and count>0; pop while empty SHALL be ignored.
REQ-025 SHALL, on simultaneous push and pop with count>0 (including full), perform both and leave count unchanged, with no drop.
REQ-026 SHALL, on simultaneous push and pop with count=0, perform the push only; the pop is ignored.
REQ-027 SHALL, on a push while full without a pop, discard the event, set overflow, and increment dropped saturating at all-ones; seq SHALL NOT advance.
REQ-028 SHALL make clear_ovf=1 zero overflow and dropped on that edge; a drop in the same cycle SHALL win (overflow=1, dropped=1).
REQ-029 SHALL let read and write pointers wrap modulo DEPTH.
REQ-030 SHALL hold out_* outputs at 0 while out_valid=0.

Reset
REQ-031 SHALL, while reset=1, asynchronously force pointers, count, seq, overflow and dropped to 0; out_valid=0 and all out_* outputs =0.
REQ-032 SHALL discard any entries in flight when reset asserts mid-operation; storage contents need not be cleared.

Configuration
REQ-033 SHALL provide macro TRACE_PC_EN: when defined, pc is stored per entry and driven on out_pc; when undefined, PC storage is omitted and out_pc is tied to 0, with all other behaviour identical.

Structure
REQ-034 SHALL place the constants SEQ_W=16, REG_ADDR_W=5, DATA_W=32 and the trace-entry record type in the shared package trace_pkg.
REQ-035 SHALL contain one sub-module, trace_fifo_mem: a DEPTH-entry storage array with a synchronous write port and a combinational read port; pointer and flag logic stays in reg_write_tracer.

Verification
REQ-036 SHALL cover a basic push: wr_en=1, wr_addr=8, wr_data=0xDEADBEEF, pc=0x40 -> the next cycle out_valid=1, out_addr=8, out_data=0xDEADBEEF, out_pc=0x40 (0 without TRACE_PC_EN), out_seq=0, count=1.
REQ-037 SHALL cover filtering: wr_en=1, wr_addr=0 for 5 cycles -> count=0, out_valid=0, seq unchanged.
REQ-038 SHALL cover overflow: 10 pushes with DEPTH=8 and no pop -> count=8, overflow=1, dropped=2; draining yields seq 0..7 in order.
REQ-039 SHALL cover full push+pop: from full, simultaneous push and pop -> count stays 8, overflow stays 0, new tail seq=8.
REQ-040 SHALL cover mid-operation reset: assert reset with count=3 -> count=0, out_valid=0, and the next accepted event has seq=0.
REQ-041 SHALL cover the clear/drop race: clear_ovf=1 in the same cycle as a full-FIFO drop -> overflow=1, dropped=1.
